// File: rtl/aes_mix_columns_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_mix_columns_seq_pkg
// Purpose  : Shared AES definitions for the sequential MixColumns block.
//            Holds the cipher-direction constants, the FSM state encoding
//            and the GF(2^8) constant multipliers.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package aes_mix_columns_seq_pkg;

   // Cipher direction, as presented on mode_i
   localparam logic AES_ENC = 1'b0;
   localparam logic AES_DEC = 1'b1;

   // Sequencer states
   typedef enum logic [1:0] {
      AES_ST_IDLE = 2'd0,
      AES_ST_BUSY = 2'd1,
      AES_ST_DONE = 2'd2
   } aes_mc_state_e;

   // Multiply by {02} modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] aes_mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by {04}: two successive doublings
   function automatic logic [7:0] aes_mul4(input logic [7:0] a);
      return aes_mul2(aes_mul2(a));
   endfunction

endpackage : aes_mix_columns_seq_pkg
`default_nettype wire

// File: rtl/aes_mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_mix_columns_seq_if
// Purpose  : Streaming bus of the sequential MixColumns block.
// Ports    : in_valid_i/in_ready_o/data_i/mode_i - input handshake
//            out_valid_o/out_ready_i/data_o     - output handshake
//            clear_i                            - synchronous flush
//            master modport: producer/consumer side (testbench)
//            slave  modport: the MixColumns block
// Revision : 1.0 - initial release
// ============================================================================
interface aes_mix_columns_seq_if;

   logic         mode_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [127:0] data_i;
   logic         clear_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [127:0] data_o;

   modport master (
      output mode_i, in_valid_i, data_i, clear_i, out_ready_i,
      input  in_ready_o, out_valid_o, data_o
   );

   modport slave (
      input  mode_i, in_valid_i, data_i, clear_i, out_ready_i,
      output in_ready_o, out_valid_o, data_o
   );

endinterface : aes_mix_columns_seq_if
`default_nettype wire

// File: rtl/aes_mix_columns_seq_single_column.sv
`default_nettype none
// ============================================================================
// Module   : aes_mix_single_column
// Purpose  : Combinational (Inv)MixColumns of one 32-bit state column.
// Ports    : col_i [31:0] - column in, row 0 in bits [31:24]
//            mode_i       - AES_ENC: MixColumns, AES_DEC: InvMixColumns
//            col_o [31:0] - transformed column, same byte order
// Revision : 1.0 - initial release
// ============================================================================
module aes_mix_single_column
   import aes_mix_columns_seq_pkg::*;
(
   input  wire logic [31:0] col_i,
   input  wire logic        mode_i,
   output logic      [31:0] col_o
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] u, v;
   logic [7:0] p0, p1, p2, p3;

   always_comb begin
      a0 = col_i[31:24];
      a1 = col_i[23:16];
      a2 = col_i[15:8];
      a3 = col_i[7:0];

      // The inverse matrix factors as MixColumns x circ(05,00,04,00), so the
      // decrypt path only needs this cheap {04} pre-step ahead of the shared
      // forward network.
      u = aes_mul4(a0 ^ a2);
      v = aes_mul4(a1 ^ a3);

      if (mode_i == AES_DEC) begin
         p0 = a0 ^ u;
         p1 = a1 ^ v;
         p2 = a2 ^ u;
         p3 = a3 ^ v;
      end else begin
         p0 = a0;
         p1 = a1;
         p2 = a2;
         p3 = a3;
      end

      // {03}x = {02}x ^ x
      col_o[31:24] = aes_mul2(p0) ^ aes_mul2(p1) ^ p1 ^ p2 ^ p3;
      col_o[23:16] = p0 ^ aes_mul2(p1) ^ aes_mul2(p2) ^ p2 ^ p3;
      col_o[15:8]  = p0 ^ p1 ^ aes_mul2(p2) ^ aes_mul2(p3) ^ p3;
      col_o[7:0]   = aes_mul2(p0) ^ p0 ^ p1 ^ p2 ^ aes_mul2(p3);
   end

endmodule : aes_mix_single_column
`default_nettype wire

// File: rtl/aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_mix_columns_seq
// Purpose  : Sequential AES (Inv)MixColumns. A captured 128-bit state is
//            transformed one column per cycle through a single shared
//            column unit, then held until the consumer takes it.
// Ports    : clk_i  - clock, rising edge
//            rst_ni - asynchronous active-low reset
//            bus    - aes_mix_columns_seq_if.slave (handshakes, data, clear)
// Revision : 1.0 - initial release
// ============================================================================
module aes_mix_columns_seq
   import aes_mix_columns_seq_pkg::*;
(
   input  wire logic              clk_i,
   input  wire logic              rst_ni,
   aes_mix_columns_seq_if.slave   bus
);

   localparam logic [1:0] IDLE = AES_ST_IDLE;
   localparam logic [1:0] BUSY = AES_ST_BUSY;
   localparam logic [1:0] DONE = AES_ST_DONE;

   logic [1:0]   state_q, state_d;
   logic [1:0]   col_cnt_q, col_cnt_d;
   logic [127:0] work_q, work_d;
   logic         mode_q, mode_d;

   logic [31:0]  col_sel;
   logic [31:0]  col_new;

   // Column c occupies bits [127-32c -: 32]
   always_comb begin
      case (col_cnt_q)
         2'd0:    col_sel = work_q[127:96];
         2'd1:    col_sel = work_q[95:64];
         2'd2:    col_sel = work_q[63:32];
         default: col_sel = work_q[31:0];
      endcase
   end

   aes_mix_single_column u_col (
      .col_i  (col_sel),
      .mode_i (mode_q),
      .col_o  (col_new)
   );

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      work_d    = work_q;
      mode_d    = mode_q;

      if (bus.clear_i) begin
         state_d   = IDLE;
         col_cnt_d = 2'd0;
         work_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid_i) begin
                  work_d    = bus.data_i;
                  mode_d    = bus.mode_i;
                  col_cnt_d = 2'd0;
                  state_d   = BUSY;
               end
            end
            BUSY: begin
               case (col_cnt_q)
                  2'd0:    work_d[127:96] = col_new;
                  2'd1:    work_d[95:64]  = col_new;
                  2'd2:    work_d[63:32]  = col_new;
                  default: work_d[31:0]   = col_new;
               endcase
               col_cnt_d = col_cnt_q + 2'd1;
               if (col_cnt_q == 2'd3) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (bus.out_ready_i) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               col_cnt_d = 2'd0;
               work_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         col_cnt_q <= 2'd0;
         work_q    <= '0;
         mode_q    <= AES_ENC;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         work_q    <= work_d;
         mode_q    <= mode_d;
      end
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   // Partially transformed states never leak onto the output bus
   assign bus.data_o      = (state_q == DONE) ? work_q : 128'h0;

endmodule : aes_mix_columns_seq
`default_nettype wire

// File: tb/tb_aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mix_columns_seq
// Purpose  : Self-checking bench for aes_mix_columns_seq: known-answer
//            table, random enc/dec round trips, DONE back-pressure, clear
//            and reset aborts, mode toggling while busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mix_columns_seq;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   aes_mix_columns_seq_if u_if ();

   aes_mix_columns_seq dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (u_if)
   );

   int checks = 0;
   int errors = 0;
   logic [127:0] sb[$];

   typedef struct {
      logic [127:0] data;
      logic         mode;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Direct circulant matrix multiply: b_r = sum_j k[(j-r) mod 4] * a_j
   function automatic logic [127:0] model(input logic [127:0] s, input logic m);
      logic [7:0]   k[4];
      logic [7:0]   a[4];
      logic [7:0]   b;
      logic [127:0] res = '0;
      if (m) begin
         k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
      end else begin
         k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[8*(15-4*c-r) +: 8];
         for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b ^= gmul(k[(j - r + 4) % 4], a[j]);
            res[8*(15-4*c-r) +: 8] = b;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one state, check latency, optional DONE hold, handshake, aftermath
   task automatic run_vec(input logic [127:0] d, input logic m, input logic [127:0] exp,
                          input string nm, input int hold, input bit toggle,
                          output logic [127:0] got);
      int w;
      int lat;
      logic [127:0] e;
      w = 0;
      while (u_if.in_ready_o !== 1'b1 && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      chk({nm, "_ready"}, {127'b0, u_if.in_ready_o}, 128'd1);
      @(negedge clk_i);
      u_if.data_i     = d;
      u_if.mode_i     = m;
      u_if.in_valid_i = 1'b1;
      @(posedge clk_i);
      sb.push_back(exp);
      #1;
      u_if.in_valid_i = 1'b0;
      u_if.data_i     = rnd128();
      u_if.mode_i     = ~m;
      lat = 1;
      while (u_if.out_valid_o !== 1'b1 && lat < 20) begin
         @(posedge clk_i);
         lat++;
         #1;
         if (toggle) begin
            u_if.mode_i     = ~u_if.mode_i;
            u_if.data_i     = rnd128();
            u_if.in_valid_i = ~u_if.in_valid_i;
         end
      end
      u_if.in_valid_i = 1'b0;
      chk({nm, "_latency"}, 128'(lat), 128'd5);
      e = (sb.size() > 0) ? sb.pop_front() : 128'hx;
      for (int i = 0; i < hold; i++) begin
         chk({nm, "_hold_valid"}, {127'b0, u_if.out_valid_o}, 128'd1);
         chk({nm, "_hold_data"}, u_if.data_o, e);
         chk({nm, "_hold_ready"}, {127'b0, u_if.in_ready_o}, 128'd0);
         u_if.in_valid_i = 1'b1;
         u_if.data_i     = rnd128();
         u_if.mode_i     = ~u_if.mode_i;
         @(posedge clk_i);
         #1;
      end
      chk({nm, "_data"}, u_if.data_o, e);
      got = u_if.data_o;
      u_if.out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      u_if.out_ready_i = 1'b0;
      u_if.in_valid_i  = 1'b0;
      chk({nm, "_post_valid"}, {127'b0, u_if.out_valid_o}, 128'd0);
      chk({nm, "_post_data"}, u_if.data_o, 128'h0);
      chk({nm, "_post_ready"}, {127'b0, u_if.in_ready_o}, 128'd1);
   endtask

   // Accept a state and let two column edges pass (counter now at 2)
   task automatic start_and_advance(input logic [127:0] d);
      @(negedge clk_i);
      u_if.data_i     = d;
      u_if.mode_i     = 1'b0;
      u_if.in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      u_if.in_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] got;
      logic [127:0] s;
      logic [127:0] c;

      vecs[0] = '{ {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}} };
      vecs[1] = '{ 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b0,
                   128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6 };
      vecs[2] = '{ 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, 1'b1,
                   128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5 };
      vecs[3] = '{ {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}} };

      u_if.mode_i      = 1'b0;
      u_if.in_valid_i  = 1'b0;
      u_if.data_i      = '0;
      u_if.clear_i     = 1'b0;
      u_if.out_ready_i = 1'b0;

      // Reset state, with in_valid asserted to show nothing is taken in reset
      #1;
      u_if.in_valid_i = 1'b1;
      u_if.data_i     = rnd128();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ready", {127'b0, u_if.in_ready_o}, 128'd1);
      chk("rst_valid", {127'b0, u_if.out_valid_o}, 128'd0);
      chk("rst_data", u_if.data_o, 128'h0);
      u_if.in_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Known-answer table
      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i].data, vecs[i].mode, vecs[i].exp, $sformatf("kat%0d", i), 0, 1'b0, got);
      end

      // Back-pressure in DONE for 10 cycles with in_valid held high
      run_vec(vecs[1].data, 1'b0, vecs[1].exp, "hold", 10, 1'b0, got);

      // Mode/data/in_valid toggling while busy
      run_vec(vecs[0].data, 1'b0, vecs[0].exp, "tog_enc", 0, 1'b1, got);
      run_vec(vecs[2].data, 1'b1, vecs[2].exp, "tog_dec", 2, 1'b1, got);

      // Clear while IDLE beats a simultaneous in_valid
      @(negedge clk_i);
      u_if.clear_i    = 1'b1;
      u_if.in_valid_i = 1'b1;
      u_if.data_i     = rnd128();
      @(posedge clk_i);
      #1;
      u_if.clear_i    = 1'b0;
      u_if.in_valid_i = 1'b0;
      chk("clr_idle_ready", {127'b0, u_if.in_ready_o}, 128'd1);

      // Clear at column 2
      start_and_advance(vecs[1].data);
      u_if.clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      u_if.clear_i = 1'b0;
      chk("clr_ready", {127'b0, u_if.in_ready_o}, 128'd1);
      chk("clr_valid", {127'b0, u_if.out_valid_o}, 128'd0);
      chk("clr_data", u_if.data_o, 128'h0);
      repeat (6) @(posedge clk_i);
      #1;
      chk("clr_stay_valid", {127'b0, u_if.out_valid_o}, 128'd0);
      run_vec(vecs[0].data, 1'b0, vecs[0].exp, "after_clr", 0, 1'b0, got);

      // Asynchronous reset mid-BUSY
      start_and_advance(vecs[0].data);
      rst_ni = 1'b0;
      #1;
      chk("arst_ready", {127'b0, u_if.in_ready_o}, 128'd1);
      chk("arst_valid", {127'b0, u_if.out_valid_o}, 128'd0);
      chk("arst_data", u_if.data_o, 128'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_vec(vecs[3].data, 1'b1, vecs[3].exp, "after_rst", 0, 1'b0, got);

      // Random encrypt-then-decrypt round trips
      for (int n = 0; n < 1000; n++) begin
         s = rnd128();
         run_vec(s, 1'b0, model(s, 1'b0), "rt_enc", 0, 1'b0, c);
         run_vec(c, 1'b1, s, "rt_dec", 0, 1'b0, got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_aes_mix_columns_seq
`default_nettype wire
